// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, VGA fetch is guaranteed
// a slot after MAXWAIT denied cycles. Read data is registered per port.
module dmem_arbiter #(
  parameter int Dbits   = 32,
  parameter int Abits   = 14,
  parameter int MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [Dbits-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic [Dbits-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             vga_req,
  input  logic [31:0]      vga_addr,
  output logic             vga_gnt,
  output logic [Dbits-1:0] vga_rdata,
  output logic             vga_rvalid,
  output logic             addr_err,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [Dbits-1:0] mem_writedata,
  input  logic [Dbits-1:0] mem_readdata
);

  localparam logic [3:0] MaxW = 4'(MAXWAIT);

  logic [3:0] wait_cnt;
  logic       cpu_r;
  logic       vga_r;
  logic       vga_force;
  logic       cpu_ok;
  logic       vga_ok;
  logic       cpu_rd;

  // Requests are ignored while reset is held so no write can slip out.
  assign cpu_r     = cpu_req & reset_n;
  assign vga_r     = vga_req & reset_n;
  assign vga_force = (wait_cnt == MaxW);

  assign cpu_gnt = cpu_r & ~(vga_r & vga_force);
  assign vga_gnt = vga_r & (~cpu_r | vga_force);

  assign cpu_ok = (cpu_addr[31:Abits] == '0);
  assign vga_ok = (vga_addr[31:Abits] == '0);
  assign cpu_rd = cpu_gnt & ~cpu_we;

  assign mem_addr      = vga_gnt ? vga_addr : cpu_addr;
  assign mem_writedata = cpu_wdata;
  assign mem_wr        = cpu_gnt & cpu_we & cpu_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt   <= '0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (!vga_r || vga_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != MaxW)
        wait_cnt <= wait_cnt + 4'd1;
      cpu_rvalid <= cpu_rd;
      vga_rvalid <= vga_gnt;
      if (cpu_rd)
        cpu_rdata <= cpu_ok ? mem_readdata : '0;
      if (vga_gnt)
        vga_rdata <= vga_ok ? mem_readdata : '0;
      addr_err <= (cpu_gnt & ~cpu_ok) | (vga_gnt & ~vga_ok);
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the MIPS CPU and the VGA display fetch engine. The CPU has fixed priority. A starvation counter guarantees the VGA port a slot after a bounded wait. The block sits between both requesters and the data memory. It drives the memory's write enable, address and write data, registers the read data back per port, and flags out-of-range accesses.

## Interface
Parameters:
- Dbits, 32, data width.
- Abits, 14, implemented word-address bits (memory depth 2^Abits = 16384 words).
- MAXWAIT, 4, consecutive denied VGA cycles before the VGA port is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  32  CPU word address.
- cpu_wdata  in  Dbits  CPU write data.
- cpu_gnt  out  1  combinational; access performed this cycle.
- cpu_rdata  out  Dbits  registered read data.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- vga_req  in  1  VGA read request (read-only port), held until granted.
- vga_addr  in  32  VGA word address.
- vga_gnt  out  1  combinational grant.
- vga_rdata  out  Dbits  registered read data.
- vga_rvalid  out  1  one-cycle pulse.
- addr_err  out  1  registered pulse; the granted access in the previous cycle was out of range.
- mem_wr  out  1  memory write enable.
- mem_addr  out  32  memory word address.
- mem_writedata  out  Dbits  memory write data.
- mem_readdata  in  Dbits  memory read data, combinational from mem_addr.

## Operation
- At most one memory access per cycle.

Grant logic (combinational):
- vga_force = (wait_cnt == MAXWAIT).
- cpu_gnt = cpu_req & ~(vga_req & vga_force).
- vga_gnt = vga_req & (~cpu_req | vga_force).
- The two grants are never both 1.

Memory mux:
- mem_addr = vga_gnt ? vga_addr : cpu_addr.
- mem_writedata = cpu_wdata.
- mem_wr = cpu_gnt & cpu_we & in_range(cpu_addr).

Range check:
- in_range(a) = (a[31:Abits] == 0).
- An out-of-range write is suppressed, so memory is unchanged.
- An out-of-range read returns 0 in rdata.
- Either case pulses addr_err.

Starvation counter wait_cnt (width 4):
- Cleared by reset, by vga_gnt, or when vga_req = 0.
- Otherwise increments each cycle in which vga_req = 1 and vga_gnt = 0.
- Saturates at MAXWAIT.

Read return:
- On a granted read, mem_readdata (or 0 if out of range) is captured into cpu_rdata / vga_rdata at the rising edge.
- The matching rvalid is high for the following cycle only.
- rdata holds its value until the next read on that port.
- A CPU write produces no rvalid.

Requester rules:
- A requester holds req, addr, we and wdata stable until it sees gnt high.
- A requester may deassert req in the cycle after gnt.
- A requester holding req after gnt is treated as a new request.

## Timing
- Reset (asynchronous assert, synchronous release): wait_cnt = 0, cpu_rdata = 0, vga_rdata = 0, cpu_rvalid = 0, vga_rvalid = 0, addr_err = 0.
- Grants and mem_* outputs are combinational from inputs and wait_cnt. With no requests: mem_wr = 0, mem_addr = cpu_addr.
- Read latency: request granted in cycle N gives rvalid high and rdata valid in cycle N+1.
- Write latency: the memory is written at the rising edge ending the grant cycle.
- Back-to-back grants to the same port in consecutive cycles are allowed, giving one access per cycle.
- Worst-case VGA wait: MAXWAIT denied cycles, then a grant on cycle MAXWAIT+1.
- Worst-case CPU wait: 1 cycle per VGA forced win.
- Simultaneous requests with wait_cnt < MAXWAIT: CPU wins and wait_cnt increments.
- Simultaneous requests with wait_cnt = MAXWAIT: VGA wins, CPU is stalled one cycle, and wait_cnt clears.
- VGA req dropped while waiting: wait_cnt clears, with no carry-over to a later request.
- Reset mid-operation: any pending rvalid/addr_err is cancelled, and no write occurs while reset_n = 0 because requests are ignored.

## Test plan
- Reset, then cpu write 0xDEADBEEF to 0x10, then cpu read 0x10 -> cpu_gnt same cycle, cpu_rvalid next cycle, cpu_rdata = 0xDEADBEEF, vga_rvalid = 0.
- VGA alone reads 0x10 -> vga_gnt immediately, vga_rdata = 0xDEADBEEF one cycle later, wait_cnt stays 0.
- cpu_req and vga_req both held high continuously, MAXWAIT = 4 -> 4 CPU grants then 1 VGA grant, repeating. The grants are never both 1.
- VGA waits 2 cycles then drops req for 1 cycle, then re-requests under constant cpu_req -> the VGA grant comes only after 4 further denied cycles.
- CPU write 0x12345678 to address 0x0000_4000 (out of range) -> mem_wr = 0, addr_err pulses next cycle, and a read of word 0x0 is unchanged. A VGA read of 0x0001_0000 -> vga_rdata = 0, addr_err = 1.
- Assert reset_n low in the cycle after a granted read -> cpu_rvalid = 0, cpu_rdata = 0, wait_cnt = 0 immediately. After release, normal grants resume.
